// File: rtl/bfx_pkg.sv
// Shared types for the bfx_core Brainfuck execution core: FSM states and opcode bytes.
package bfx_pkg;

   typedef enum logic [3:0] {
      CLEAR,
      IDLE,
      FETCH,
      EXEC,
      SKIP,
      OUT_WAIT,
      IN_WAIT,
      HALT,
      ERROR
   } bfx_state_e;

   localparam logic [7:0] OP_INC   = 8'h2B;
   localparam logic [7:0] OP_DEC   = 8'h2D;
   localparam logic [7:0] OP_RIGHT = 8'h3E;
   localparam logic [7:0] OP_LEFT  = 8'h3C;
   localparam logic [7:0] OP_OUT   = 8'h2E;
   localparam logic [7:0] OP_IN    = 8'h2C;
   localparam logic [7:0] OP_LOOP  = 8'h5B;
   localparam logic [7:0] OP_END   = 8'h5D;
   localparam logic [7:0] OP_HALT  = 8'h00;

endpackage

// File: rtl/bfx_loop_stack.sv
// Loop return-address stack: push/pop/top with full and empty flags.
// DEPTH must be a power of two, at least 2; sp counts 0..DEPTH.
module bfx_loop_stack #(
   parameter int DEPTH = 16,
   parameter int W     = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] top_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = AW + 1;

   logic [W-1:0]   mem_q [DEPTH];
   logic [SPW-1:0] sp_q, sp_d;
   logic [AW-1:0]  top_idx;

   assign full_o  = (sp_q == SPW'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign top_idx = sp_q[AW-1:0] - 1'b1;
   assign top_o   = mem_q[top_idx];

   always_comb begin
      sp_d = sp_q;
      if (push_i && !full_o)
         sp_d = sp_q + 1'b1;
      else if (pop_i && !empty_o)
         sp_d = sp_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         sp_q <= '0;
      else
         sp_q <= sp_d;
   end

   // Entries need no reset: sp alone defines which ones are live.
   always_ff @(posedge clk_i) begin
      if (!rst_i && push_i && !full_o)
         mem_q[sp_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/bfx_core.sv
// Brainfuck execution core: fetch/execute FSM, data-cell array, loop stack and skip scanner.
// Optional macro BFX_CELL_SAT_EN makes '+'/'-' saturate instead of wrapping.
module bfx_core
   import bfx_pkg::*;
#(
   parameter int PC_W        = 16,
   parameter int DP_W        = 10,
   parameter int CELL_W      = 8,
   parameter int STACK_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [PC_W-1:0]   prog_addr,
   input  logic [7:0]        prog_data,
   input  logic [CELL_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [CELL_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              halted,
   output logic              error
);

   localparam int NCELL = 1 << DP_W;

   bfx_state_e        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
   logic [DP_W-1:0]   dp_q, dp_d;
   logic [DP_W-1:0]   clr_q, clr_d;
   logic [PC_W-1:0]   skip_q, skip_d;
   logic              skip_ph_q, skip_ph_d;
   logic [CELL_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              halted_q, halted_d;
   logic              error_q, error_d;

   logic [CELL_W-1:0] cells_q [NCELL];
   logic [CELL_W-1:0] cell_rd, cell_inc, cell_dec, mem_wdata;
   logic [DP_W-1:0]   mem_waddr;
   logic              mem_we;

   logic              push, pop, stk_full, stk_empty;
   logic [PC_W-1:0]   stk_top;

   assign cell_rd = cells_q[dp_q];
   assign pc_inc  = pc_q + 1'b1;

`ifdef BFX_CELL_SAT_EN
   assign cell_inc = (cell_rd == '1) ? cell_rd : cell_rd + 1'b1;
   assign cell_dec = (cell_rd == '0) ? cell_rd : cell_rd - 1'b1;
`else
   assign cell_inc = cell_rd + 1'b1;
   assign cell_dec = cell_rd - 1'b1;
`endif

   bfx_loop_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (PC_W)
   ) u_stack (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (pc_inc),
      .top_o   (stk_top),
      .full_o  (stk_full),
      .empty_o (stk_empty)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      dp_d        = dp_q;
      clr_d       = clr_q;
      skip_d      = skip_q;
      skip_ph_d   = skip_ph_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      halted_d    = halted_q;
      error_d     = error_q;
      mem_we      = 1'b0;
      mem_waddr   = dp_q;
      mem_wdata   = cell_rd;
      push        = 1'b0;
      pop         = 1'b0;

      unique case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_q;
            mem_wdata = '0;
            clr_d     = clr_q + 1'b1;
            if (clr_q == '1)
               state_d = IDLE;
         end
         IDLE: begin
            if (start) begin
               pc_d    = '0;
               state_d = FETCH;
            end
         end
         FETCH: state_d = EXEC;
         EXEC: begin
            state_d = FETCH;
            pc_d    = pc_inc;
            case (prog_data)
               OP_RIGHT: dp_d = dp_q + 1'b1;
               OP_LEFT:  dp_d = dp_q - 1'b1;
               OP_INC: begin
                  mem_we    = 1'b1;
                  mem_wdata = cell_inc;
               end
               OP_DEC: begin
                  mem_we    = 1'b1;
                  mem_wdata = cell_dec;
               end
               OP_OUT: begin
                  out_data_d  = cell_rd;
                  out_valid_d = 1'b1;
                  pc_d        = pc_q;
                  state_d     = OUT_WAIT;
               end
               OP_IN: begin
                  in_ready_d = 1'b1;
                  pc_d       = pc_q;
                  state_d    = IN_WAIT;
               end
               OP_LOOP: begin
                  if (cell_rd != '0) begin
                     if (stk_full) begin
                        error_d = 1'b1;
                        pc_d    = pc_q;
                        state_d = ERROR;
                     end else begin
                        push = 1'b1;
                     end
                  end else begin
                     skip_d    = PC_W'(1);
                     skip_ph_d = 1'b0;
                     state_d   = SKIP;
                  end
               end
               OP_END: begin
                  if (stk_empty) begin
                     error_d = 1'b1;
                     pc_d    = pc_q;
                     state_d = ERROR;
                  end else if (cell_rd != '0) begin
                     pc_d = stk_top;
                  end else begin
                     pop = 1'b1;
                  end
               end
               OP_HALT: begin
                  halted_d = 1'b1;
                  pc_d     = pc_q;
                  state_d  = HALT;
               end
               default: ;
            endcase
         end
         // Phase 0 lets the ROM see pc; phase 1 scans the returned byte.
         SKIP: begin
            if (!skip_ph_q) begin
               skip_ph_d = 1'b1;
            end else begin
               skip_ph_d = 1'b0;
               pc_d      = pc_inc;
               case (prog_data)
                  OP_LOOP: skip_d = skip_q + 1'b1;
                  OP_END: begin
                     skip_d = skip_q - 1'b1;
                     if (skip_q == PC_W'(1))
                        state_d = FETCH;
                  end
                  OP_HALT: begin
                     halted_d = 1'b1;
                     pc_d     = pc_q;
                     state_d  = HALT;
                  end
                  default: ;
               endcase
            end
         end
         OUT_WAIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               pc_d        = pc_inc;
               state_d     = FETCH;
            end
         end
         IN_WAIT: begin
            if (in_valid) begin
               mem_we     = 1'b1;
               mem_wdata  = in_data;
               in_ready_d = 1'b0;
               pc_d       = pc_inc;
               state_d    = FETCH;
            end
         end
         HALT, ERROR: ;
         default: state_d = ERROR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR;
         pc_q        <= '0;
         dp_q        <= '0;
         clr_q       <= '0;
         skip_q      <= '0;
         skip_ph_q   <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         halted_q    <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         dp_q        <= dp_d;
         clr_q       <= clr_d;
         skip_q      <= skip_d;
         skip_ph_q   <= skip_ph_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         halted_q    <= halted_d;
         error_q     <= error_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && mem_we)
         cells_q[mem_waddr] <= mem_wdata;
   end

   assign prog_addr = pc_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign halted    = halted_q;
   assign error     = error_q;
   assign busy      = !(state_q inside {IDLE, HALT, ERROR});

endmodule

// File: tb/tb_bfx_core.sv
// Scoreboard bench for bfx_core: directed programs, expected output bytes queued at issue time.
module tb_bfx_core;
   localparam int PC_W = 8, DP_W = 4, CELL_W = 8, SD = 2;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [PC_W-1:0]   prog_addr;
   logic [7:0]        prog_data = 8'h00;
   logic [CELL_W-1:0] in_data = '0, out_data;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic busy, halted, error;

   logic [7:0] rom [0:255];
   logic [7:0] expq [$];
   int n_tests = 0, n_fail = 0, n_xfer = 0, addr5_cnt = 0;

`ifdef BFX_CELL_SAT_EN
   localparam logic [7:0] EXP_WRAP = 8'h00;
`else
   localparam logic [7:0] EXP_WRAP = 8'hFF;
`endif

   bfx_core #(.PC_W(PC_W), .DP_W(DP_W), .CELL_W(CELL_W), .STACK_DEPTH(SD)) dut (
      .clk(clk), .rst(rst), .start(start), .prog_addr(prog_addr), .prog_data(prog_data),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .halted(halted), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) prog_data <= rom[prog_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every completed output handshake pops one expected byte.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_xfer++;
         if (expq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h expected none", out_data);
         end else begin
            chk("out_data", out_data, expq.pop_front());
         end
      end
      if (busy && prog_addr == 8'd5) addr5_cnt++;
   end

   task automatic load(input string s);
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      for (int i = 0; i < s.len(); i++) rom[i] = s[i];
   endtask

   task automatic do_reset();
      int n;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("rst_busy", busy, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_flags", {halted, error}, 0);
      chk("rst_prog_addr", prog_addr, 0);
      chk("rst_out_data", out_data, 0);
      n = 0;
      while (busy && n < 100) begin
         if (n == 3) start = 1'b1;   // start during CLEAR must be ignored
         @(posedge clk); #1 n++;
         start = 1'b0;
      end
      chk("clear_cycles", n, 16);
   endtask

   task automatic run();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!(halted || error) && n < 500) begin
         @(posedge clk); #1 n++;
      end
      chk("done_in_time", n < 500, 1);
   endtask

   task automatic wait_sig(input string name, input bit which_out);
      int n = 0;
      while (!(which_out ? out_valid : in_ready) && n < 200) begin
         @(posedge clk); #1 n++;
      end
      chk(name, n < 200, 1);
   endtask

   task automatic end_test(input int x0, input int nx);
      chk("xfer_count", n_xfer - x0, nx);
      chk("queue_empty", expq.size(), 0);
   endtask

   initial begin
      int x0;
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int x0, n;
      // 1: "+++." -> 0x03 then halt
      load("+++."); do_reset();
      x0 = n_xfer; expq.push_back(8'h03);
      run(); wait_done();
      chk("t1_halted", halted, 1); chk("t1_busy", busy, 0); chk("t1_error", error, 0);
      end_test(x0, 1);

      // 2: ",+." with late input and back-pressured output
      load(",+."); out_ready = 1'b0; do_reset();
      x0 = n_xfer; expq.push_back(8'h42);
      run(); wait_sig("t2_in_ready", 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      chk("t2_in_ready_held", in_ready, 1);
      in_data = 8'h41; in_valid = 1'b1;
      n = 0;
      while (in_ready && n < 10) begin @(posedge clk); #1 n++; end
      in_valid = 1'b0;
      chk("t2_in_accept_cycles", n, 1);
      wait_sig("t2_out_valid", 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
         chk("t2_hold_valid", out_valid, 1);
         chk("t2_hold_data", out_data, 8'h42);
      end
      out_ready = 1'b1;
      wait_done();
      chk("t2_halted", halted, 1);
      end_test(x0, 1);

      // 3: "++++[->++<]>." -> 0x08, body at pc 5 seen 4 times (2 cycles each)
      load("++++[->++<]>."); do_reset();
      x0 = n_xfer; expq.push_back(8'h08); addr5_cnt = 0;
      run(); wait_done();
      chk("t3_body_cycles", addr5_cnt, 8); chk("t3_halted", halted, 1);
      end_test(x0, 1);

      // 4: "[+[+]+]." with cell 0 -> nested skip, output 0x00
      load("[+[+]+]."); do_reset();
      x0 = n_xfer; expq.push_back(8'h00);
      run(); wait_done();
      chk("t4_halted", halted, 1); chk("t4_error", error, 0);
      end_test(x0, 1);

      // 5a: STACK_DEPTH=2, "+[[[" -> error at third '[' (pc 3)
      load("+[[["); do_reset();
      x0 = n_xfer;
      run(); wait_done();
      chk("t5_error", error, 1); chk("t5_halted", halted, 0);
      chk("t5_busy", busy, 0); chk("t5_err_pc", prog_addr, 3);
      end_test(x0, 0);

      // 5b: "]" alone -> underflow error
      load("]"); do_reset();
      run(); wait_done();
      chk("t5b_error", error, 1); chk("t5b_err_pc", prog_addr, 0);

      // 6: "<-." -> dp wraps, outputs 0xFF (0x00 when saturating)
      load("<-."); do_reset();
      x0 = n_xfer; expq.push_back(EXP_WRAP);
      run(); wait_done();
      chk("t6_halted", halted, 1);
      end_test(x0, 1);

      // 6b: reset while in OUT_WAIT drops out_valid, no transfer
      out_ready = 1'b0; do_reset();
      x0 = n_xfer;
      run(); wait_sig("t6b_out_valid", 1'b1);
      chk("t6b_out_data", out_data, EXP_WRAP);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6b_valid_dropped", out_valid, 0);
      chk("t6b_busy", busy, 1);
      rst = 1'b0; out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      end_test(x0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
